// File: rtl/csr_pwm_leds.sv
// LED block on the CSR bus: on-mask, per-LED blink mask and a global PWM
// brightness with a programmable blink half-period.
module csr_pwm_leds #(
    parameter logic [11:0]      BASE_ADDR = 12'h7c1,
    parameter int               WIDTH     = 8,
    parameter int               PWM_BITS  = 8,
    parameter int               PRESCALE  = 16,
    parameter logic [WIDTH-1:0] RESET_ON  = WIDTH'('h81)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             read,
    input  logic [1:0]       modify,
    input  logic [31:0]      wdata,
    input  logic [11:0]      addr,
    output logic [31:0]      rdata,
    output logic             valid,
    output logic [WIDTH-1:0] leds
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam logic [11:0] A_ON    = BASE_ADDR;
    localparam logic [11:0] A_BLINK = BASE_ADDR + 12'd1;
    localparam logic [11:0] A_CTRL  = BASE_ADDR + 12'd2;

    logic [WIDTH-1:0]    on_q, blink_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [15:0]         half_q;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         blink_cnt;
    logic                phase;

    logic                unused_read;
    assign unused_read = read;

    function automatic logic [31:0] apply_op(
        input logic [1:0]  op,
        input logic [31:0] cur,
        input logic [31:0] wd
    );
        logic [31:0] r;
        r = cur;
        case (op)
            2'b01:   r = wd;
            2'b10:   r = cur | wd;
            2'b11:   r = cur & ~wd;
            default: r = cur;
        endcase
        return r;
    endfunction

    logic [31:0]         on_ext, blink_ext, ctrl_ext;
    logic [31:0]         on_new, blink_new, ctrl_new;
    logic [31:0]         rd_nxt;
    logic                hit;
    logic                ctrl_wr;
    logic [WIDTH-1:0]    on_nxt, blink_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [15:0]         half_nxt;

    assign on_ext    = 32'(on_q);
    assign blink_ext = 32'(blink_q);
    assign ctrl_ext  = {half_q, 16'(duty_q)};
    assign on_new    = apply_op(modify, on_ext, wdata);
    assign blink_new = apply_op(modify, blink_ext, wdata);
    assign ctrl_new  = apply_op(modify, ctrl_ext, wdata);

    always_comb begin
        rd_nxt    = '0;
        hit       = 1'b0;
        ctrl_wr   = 1'b0;
        on_nxt    = on_q;
        blink_nxt = blink_q;
        duty_nxt  = duty_q;
        half_nxt  = half_q;
        unique case (1'b1)
            (addr == A_ON): begin
                hit    = 1'b1;
                rd_nxt = on_ext;
                on_nxt = on_new[WIDTH-1:0];
            end
            (addr == A_BLINK): begin
                hit       = 1'b1;
                rd_nxt    = blink_ext;
                blink_nxt = blink_new[WIDTH-1:0];
            end
            (addr == A_CTRL): begin
                hit      = 1'b1;
                rd_nxt   = ctrl_ext;
                ctrl_wr  = (modify != 2'b00);
                duty_nxt = ctrl_new[PWM_BITS-1:0];
                half_nxt = ctrl_new[31:16];
            end
            default: ;
        endcase
    end

    logic tick, period_end, pwm_on;
    assign tick       = (prescaler == PS_MAX);
    assign period_end = tick && (pwm_cnt == PWM_MAX);
    assign pwm_on     = (duty_q == PWM_MAX) || (pwm_cnt < duty_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            on_q    <= RESET_ON;
            blink_q <= '0;
            duty_q  <= '1;
            half_q  <= '0;
            rdata   <= '0;
            valid   <= 1'b0;
        end else begin
            on_q    <= on_nxt;
            blink_q <= blink_nxt;
            duty_q  <= duty_nxt;
            half_q  <= half_nxt;
            rdata   <= rd_nxt;
            valid   <= hit;
        end
    end

    // A CTRL write restarts the timebase so a new setting starts in phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (ctrl_wr) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (period_end) begin
                if (blink_cnt >= half_q) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            leds <= '0;
        else
            leds <= on_q & {WIDTH{pwm_on}} & (~blink_q | {WIDTH{phase}});
    end

endmodule
